// File: rtl/ifu_fetch.sv
// Registered instruction fetch stage: owns the fetch PC, issues word reads to imem,
// buffers {pc, inst} for the decoder and squashes stale fetches on a redirect.
module ifu_fetch #(
    parameter int unsigned       ADDR_W = 64,
    parameter int unsigned       INST_W = 32,
    parameter int unsigned       DEPTH  = 2,
    parameter logic [ADDR_W-1:0] PC_RST = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 2;

    // Handshakes: a transfer happens on a posedge where valid & ready are both high;
    // once raised, valid and its payload stay stable until that transfer, and valid
    // never depends combinationally on ready.
    logic [ADDR_W-1:0] fetchPc;
    logic              reqValid;
    logic [ADDR_W-1:0] reqAddr;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  fifoCount;
    logic [PTR_W-1:0]  fifoRd;
    logic [PTR_W-1:0]  fifoWr;
    logic [PTR_W-1:0]  pqRd;
    logic [PTR_W-1:0]  pqWr;
    logic [INST_W-1:0] instMem [DEPTH];
    logic [ADDR_W-1:0] pcMem   [DEPTH];
    logic [ADDR_W-1:0] pcQueue [DEPTH];

    logic              accept;
    logic              respTaken;
    logic              push;
    logic              pop;
    logic              issue;
    logic              reqPendingNext;
    logic [CNT_W-1:0]  inflightNext;
    logic [OCC_W-1:0]  occ;
    logic [1:0]        unusedRedirectLow;

    assign unusedRedirectLow = redirect_pc[1:0];

    always_comb begin
        accept         = reqValid & imem_req_ready;
        respTaken      = imem_resp_valid & (inflight != '0);
        pop            = (fifoCount != '0) & out_ready;
        push           = respTaken & ~redirect_valid & (drop == '0);
        reqPendingNext = reqValid & ~imem_req_ready;
        inflightNext   = inflight + CNT_W'(accept) - CNT_W'(respTaken);
        // Every pending or in-flight fetch must have a guaranteed FIFO slot; only an
        // entry leaving the FIFO this cycle frees space early.
        occ   = OCC_W'(fifoCount) - OCC_W'(pop) + OCC_W'(inflight) + OCC_W'(reqValid);
        issue = ~redirect_valid & ~reqPendingNext & (occ < OCC_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc   <= PC_RST;
            reqValid  <= 1'b0;
            reqAddr   <= PC_RST;
            inflight  <= '0;
            drop      <= '0;
            fifoCount <= '0;
            fifoRd    <= '0;
            fifoWr    <= '0;
            pqRd      <= '0;
            pqWr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instMem[i] <= '0;
                pcMem[i]   <= PC_RST;
                pcQueue[i] <= PC_RST;
            end
        end else begin
            if (accept) begin
                pcQueue[pqWr] <= reqAddr;
                pqWr          <= pqWr + PTR_W'(1);
            end
            if (respTaken) begin
                pqRd <= pqRd + PTR_W'(1);
            end
            inflight <= inflightNext;

            if (issue) begin
                reqValid <= 1'b1;
                reqAddr  <= fetchPc;
            end else if (accept) begin
                reqValid <= 1'b0;
            end

            if (redirect_valid) begin
                fetchPc   <= {redirect_pc[ADDR_W-1:2], 2'b00};
                drop      <= inflightNext + CNT_W'(reqPendingNext);
                fifoCount <= '0;
                fifoRd    <= '0;
                fifoWr    <= '0;
            end else begin
                if (issue) begin
                    fetchPc <= fetchPc + ADDR_W'(4);
                end
                if (respTaken && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
                if (push) begin
                    instMem[fifoWr] <= imem_resp_data;
                    pcMem[fifoWr]   <= pcQueue[pqRd];
                    fifoWr          <= fifoWr + PTR_W'(1);
                end
                if (pop) begin
                    fifoRd <= fifoRd + PTR_W'(1);
                end
                fifoCount <= fifoCount + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && !pop && (fifoCount == CNT_W'(DEPTH))));
        end
    end

    assign imem_req_valid = reqValid;
    assign imem_req_addr  = reqAddr;
    assign out_valid      = (fifoCount != '0);
    assign out_inst       = instMem[fifoRd];
    assign out_pc         = pcMem[fifoRd];

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a behavioural in-order memory plus a program-order stream model
// (next expected PC, restarted at each redirect target) checks every instruction consumed.
module tb_ifu_fetch;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam int DEPTH  = 2;
    localparam logic [ADDR_W-1:0] PC_RST = 64'h8000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b0;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid = 1'b0;
    logic [INST_W-1:0] imem_resp_data = '0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    ifu_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .PC_RST(PC_RST)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    int total = 0;
    int bad = 0;

    int unsigned now = 0;
    int unsigned readyPct = 100;
    int unsigned outPct = 100;
    int unsigned latMin = 1;
    int unsigned latMax = 1;
    bit occCheck = 0;
    bit redirReq = 0;
    logic [ADDR_W-1:0] redirAddr = '0;
    bit coincideArm = 0;
    bit coincideFired = 0;
    logic [ADDR_W-1:0] coincideAddr = '0;

    logic [ADDR_W-1:0] memQ[$];
    int unsigned       dueQ[$];
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] expPc = PC_RST;
    logic [ADDR_W-1:0] lastPopPc = '0;
    int accepted = 0;
    int popped = 0;
    bit holdPrev = 0;
    logic [ADDR_W-1:0] holdAddr = '0;

    function automatic logic [INST_W-1:0] memData(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, check, then drive the next cycle's inputs.
    task automatic cycle();
        @(negedge clk);
        now++;
        if (holdPrev) begin
            check("req_hold_valid", 64'(imem_req_valid), 64'd1);
            check("req_hold_addr", imem_req_addr, holdAddr);
        end
        if (occCheck)
            check("occupancy_bound", 64'((accepted - popped + int'(imem_req_valid)) <= DEPTH), 64'd1);

        imem_req_ready  = ($urandom_range(99) < readyPct);
        out_ready       = ($urandom_range(99) < outPct);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (memQ.size() > 0 && dueQ[0] <= now) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memData(memQ[0]);
            void'(memQ.pop_front());
            void'(dueQ.pop_front());
        end
        redirect_valid = redirReq;
        redirect_pc    = redirAddr;
        redirReq       = 0;
        if (coincideArm && out_valid && out_ready && imem_resp_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = coincideAddr;
            coincideArm    = 0;
            coincideFired  = 1;
        end

        holdPrev = imem_req_valid && !imem_req_ready;
        holdAddr = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            memQ.push_back(imem_req_addr);
            dueQ.push_back(now + $urandom_range(latMax, latMin));
            if (exp_q.size() > 0)
                check("req_addr_seq", imem_req_addr, exp_q.pop_front());
            accepted++;
        end

        if (out_valid && out_ready) begin
            check("out_pc", out_pc, expPc);
            check("out_inst", 64'(out_inst), 64'(memData(expPc)));
            lastPopPc = out_pc;
            expPc += 64'd4;
            popped++;
        end
        if (redirect_valid)
            expPc = {redirect_pc[ADDR_W-1:2], 2'b00};
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        rst             = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        out_ready       = 1'b0;
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", imem_req_addr, PC_RST);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_pc", out_pc, PC_RST);
        repeat (cycles) @(negedge clk);
        rst      = 1'b1;
        expPc    = PC_RST;
        holdPrev = 0;
        accepted = 0;
        popped   = 0;
    endtask

    task automatic waitPop(input string tag, input logic [ADDR_W-1:0] want, input int budget);
        int startPops;
        bit got;
        startPops = popped;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (popped != startPops) got = 1;
        end
        check({tag, "_seen"}, 64'(got), 64'd1);
        if (got) check(tag, lastPopPc, want);
    endtask

    task automatic waitInflight(input string tag, input int n, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (memQ.size() == n) got = 1;
        end
        check(tag, 64'(got), 64'd1);
    endtask

    logic [ADDR_W-1:0] stalledAddr;

    initial begin
        // reset then free run with 1-cycle memory
        applyReset(3);
        exp_q = '{PC_RST, PC_RST + 64'd4, PC_RST + 64'd8};
        cycle();
        check("rel1_req_valid", 64'(imem_req_valid), 64'd1);
        check("rel1_req_addr", imem_req_addr, PC_RST);
        check("rel1_out_valid", 64'(out_valid), 64'd0);
        cycle();
        check("rel2_out_valid", 64'(out_valid), 64'd0);
        cycle();
        check("rel3_out_valid", 64'(out_valid), 64'd1);
        check("rel3_out_pc", out_pc, PC_RST);
        repeat (30) cycle();
        check("free_run_progress", 64'(popped >= 16), 64'd1);
        check("req_seq_consumed", 64'(exp_q.size()), 64'd0);

        // decoder stall: bounded occupancy, request side goes idle
        occCheck = 1;
        outPct = 0;
        repeat (10) cycle();
        check("stall_req_idle", 64'(imem_req_valid), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_buffered", 64'(accepted - popped), 64'd2);
        outPct = 100;
        repeat (10) cycle();
        occCheck = 0;

        // memory not ready, redirect while a request is pending
        readyPct = 0;
        cycle();
        cycle();
        check("mem_stall_req_valid", 64'(imem_req_valid), 64'd1);
        stalledAddr = imem_req_addr;
        redirReq = 1;
        redirAddr = 64'h8000_0100;
        repeat (3) cycle();
        check("redir_hold_addr", imem_req_addr, stalledAddr);
        readyPct = 100;
        waitPop("redir_stall_pc", 64'h8000_0100, 20);

        // redirect with a full FIFO, unaligned target
        outPct = 0;
        repeat (8) cycle();
        check("full_out_valid", 64'(out_valid), 64'd1);
        redirReq = 1;
        redirAddr = 64'h8000_0203;
        cycle();
        cycle();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        outPct = 100;
        waitPop("redir_full_pc", 64'h8000_0200, 20);

        // redirect with two responses in flight
        latMin = 4;
        latMax = 4;
        waitInflight("two_inflight", 2, 20);
        redirReq = 1;
        redirAddr = 64'h8000_0400;
        cycle();
        latMin = 1;
        latMax = 1;
        waitPop("redir_inflight_pc", 64'h8000_0400, 30);

        // redirect coinciding with a response and a pop
        coincideArm = 1;
        coincideAddr = 64'h8000_0602;
        for (int i = 0; i < 40 && !coincideFired; i++) cycle();
        check("coincide_fired", 64'(coincideFired), 64'd1);
        coincideArm = 0;
        waitPop("coincide_pc", 64'h8000_0600, 20);

        // reset with two requests outstanding, stale responses afterwards
        latMin = 6;
        latMax = 6;
        waitInflight("rst_two_inflight", 2, 20);
        applyReset(2);
        readyPct = 0;
        latMin = 1;
        latMax = 1;
        for (int i = 0; i < 20 && memQ.size() > 0; i++) cycle();
        check("stale_drained", 64'(memQ.size()), 64'd0);
        cycle();
        check("stale_out_valid", 64'(out_valid), 64'd0);
        check("stale_req_addr", imem_req_addr, PC_RST);
        readyPct = 100;
        waitPop("rst_first_pc", PC_RST, 20);

        // randomized traffic with occasional redirects
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) begin
                readyPct = $urandom_range(100, 30);
                outPct   = $urandom_range(100, 20);
                latMax   = $urandom_range(5, 1);
            end
            if ($urandom_range(99) < 3) begin
                redirReq  = 1;
                redirAddr = PC_RST + 64'($urandom_range(65535, 0));
            end
            cycle();
        end
        check("random_progress", 64'(popped > 100), 64'd1);

        readyPct = 100;
        outPct = 100;
        latMax = 1;
        repeat (10) cycle();
        waitPop("final_flow", expPc, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
